// File: rtl/biquad_cascade.sv
// Multi-channel cascade of Direct Form I biquad sections sharing one 5-multiplier
// datapath, one section per clock, with per-channel history and saturating sums.
module biquad_cascade #(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 20,
   parameter int STAGES   = 4,
   parameter int CHANNELS = 2,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int AW      = $clog2(5 * STAGES)
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic [CW-1:0]           ch_in,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic                    coeff_we_in,
   input  logic [AW-1:0]           coeff_addr_in,
   input  logic signed [WIDTH-1:0] coeff_data_in,
   input  logic                    clear_in,
   output logic                    valid_out,
   output logic [CW-1:0]           ch_out,
   output logic signed [WIDTH-1:0] y_out,
   output logic                    sat_out,
   output logic                    coeff_drop_out
);

   localparam int SGW = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam int PW  = 2 * WIDTH;
   localparam int SW  = 2 * WIDTH + 3;
   localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
   localparam logic signed [SW-1:0]    MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0]    MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state, next_state;

   logic signed [WIDTH-1:0] coeff [STAGES][5];
   // Pair j is the input history of section j and the output history of section j-1.
   logic signed [WIDTH-1:0] hist_1 [CHANNELS][STAGES+1];
   logic signed [WIDTH-1:0] hist_2 [CHANNELS][STAGES+1];

   logic [SGW-1:0]          stage;
   logic [CW-1:0]           ch_reg;
   logic signed [WIDTH-1:0] x_reg;
   logic signed [WIDTH-1:0] prev_v;
   logic                    sat_acc;

   logic                    ch_ok;
   logic                    accept;
   logic                    last;
   logic signed [WIDTH-1:0] k_c [5];
   logic signed [WIDTH-1:0] u, u1, u2, v1, v2, v;
   logic signed [PW-1:0]    prod [5];
   logic signed [SW-1:0]    term [5];
   logic signed [SW-1:0]    sum;
   logic                    sat_hi, sat_lo, sat_now;

   assign ready_out = (state == IDLE) && !clear_in;
   assign accept    = ready_out && valid_in && ch_ok;
   assign last      = (stage == SGW'(STAGES - 1));

   always_comb begin
      ch_ok = 1'b0;
      for (int c = 0; c < CHANNELS; c++)
         if (ch_in == CW'(c)) ch_ok = 1'b1;
   end

   always_comb begin
      for (int k = 0; k < 5; k++) k_c[k] = '0;
      u1 = '0;
      u2 = '0;
      v1 = '0;
      v2 = '0;
      for (int i = 0; i < STAGES; i++)
         if (stage == SGW'(i))
            for (int k = 0; k < 5; k++) k_c[k] = coeff[i][k];
      for (int c = 0; c < CHANNELS; c++)
         for (int j = 0; j < STAGES; j++)
            if (ch_reg == CW'(c) && stage == SGW'(j)) begin
               u1 = hist_1[c][j];
               u2 = hist_2[c][j];
               v1 = hist_1[c][j+1];
               v2 = hist_2[c][j+1];
            end
   end

   assign u       = (stage == '0) ? x_reg : prev_v;
   assign prod[0] = PW'(k_c[0]) * PW'(u);
   assign prod[1] = PW'(k_c[1]) * PW'(u1);
   assign prod[2] = PW'(k_c[2]) * PW'(u2);
   assign prod[3] = PW'(k_c[3]) * PW'(v1);
   assign prod[4] = PW'(k_c[4]) * PW'(v2);

   always_comb begin
      for (int k = 0; k < 5; k++) term[k] = SW'(prod[k] >>> FRAC);
   end

   // Wide enough that five terms can never wrap before the clamp.
   assign sum     = term[0] + term[1] + term[2] - term[3] - term[4];
   assign sat_hi  = (sum > MAXV);
   assign sat_lo  = (sum < MINV);
   assign sat_now = sat_hi || sat_lo;
   assign v       = sat_hi ? {1'b0, {(WIDTH-1){1'b1}}} :
                    sat_lo ? {1'b1, {(WIDTH-1){1'b0}}} : sum[WIDTH-1:0];

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = BUSY;
         BUSY:    if (last) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= next_state;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int i = 0; i < STAGES; i++) begin
            coeff[i][0] <= ONE;
            for (int k = 1; k < 5; k++) coeff[i][k] <= '0;
         end
         for (int c = 0; c < CHANNELS; c++)
            for (int j = 0; j <= STAGES; j++) begin
               hist_1[c][j] <= '0;
               hist_2[c][j] <= '0;
            end
         stage          <= '0;
         ch_reg         <= '0;
         x_reg          <= '0;
         prev_v         <= '0;
         sat_acc        <= 1'b0;
         valid_out      <= 1'b0;
         ch_out         <= '0;
         y_out          <= '0;
         sat_out        <= 1'b0;
         coeff_drop_out <= 1'b0;
      end else begin
         valid_out      <= 1'b0;
         coeff_drop_out <= (state == BUSY) && coeff_we_in;
         if (state == IDLE) begin
            if (coeff_we_in)
               for (int i = 0; i < STAGES; i++)
                  for (int k = 0; k < 5; k++)
                     if (coeff_addr_in == AW'(i * 5 + k)) coeff[i][k] <= coeff_data_in;
            if (clear_in) begin
               for (int c = 0; c < CHANNELS; c++)
                  for (int j = 0; j <= STAGES; j++) begin
                     hist_1[c][j] <= '0;
                     hist_2[c][j] <= '0;
                  end
            end else if (accept) begin
               x_reg   <= x_in;
               ch_reg  <= ch_in;
               stage   <= '0;
               sat_acc <= 1'b0;
            end
         end else begin
            for (int c = 0; c < CHANNELS; c++)
               if (ch_reg == CW'(c)) begin
                  for (int j = 0; j < STAGES; j++)
                     if (stage == SGW'(j)) begin
                        hist_2[c][j] <= hist_1[c][j];
                        hist_1[c][j] <= u;
                     end
                  if (last) begin
                     hist_2[c][STAGES] <= hist_1[c][STAGES];
                     hist_1[c][STAGES] <= v;
                  end
               end
            prev_v  <= v;
            sat_acc <= sat_acc || sat_now;
            stage   <= stage + 1'b1;
            if (last) begin
               y_out     <= v;
               ch_out    <= ch_reg;
               sat_out   <= sat_acc || sat_now;
               valid_out <= 1'b1;
            end
         end
      end
   end

endmodule
